sextium_io_port: RTL and testbench
==================================

Name: sextium_io_port

Overview:
- I/O peripheral on the core's io_bus/ioack side of the Sextium III.
- Accepts core output words (io_write) into a TX FIFO, drained by an external stream sink.
- Serves core input requests (io_read) from an RX FIFO, filled by an external stream source.
- Stalls the core's I/O handshake, by withholding ioack, whenever the needed FIFO is full or empty.

Parameters:
- DEPTH_LOG2, 2, log2 of each FIFO depth (default depth 4 words).
- WIDTH, 16, data word width; must match io_bus.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_bus  inout  WIDTH  shared core I/O data bus; driven by this block only during reads.
- io_read  input  1  core requests an input word; held high until ioack is seen.
- io_write  input  1  core presents an output word on io_bus; held high until ioack is seen.
- ioack  output  1  one-cycle completion pulse to the core.
- tx_data  output  WIDTH  head of TX FIFO.
- tx_valid  output  1  TX FIFO not empty.
- tx_ready  input  1  external sink accepts tx_data this cycle.
- rx_data  input  WIDTH  external input word.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  RX FIFO not full.
- tx_count  output  DEPTH_LOG2+1  TX FIFO occupancy.
- rx_count  output  DEPTH_LOG2+1  RX FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs are empty; counts are 0.
  - FSM is in IDLE; ioack=0; io_bus is released to Z.
  - tx_valid=0; rx_ready=1.
- External stream side:
  - TX pops on each clock edge where tx_valid & tx_ready.
  - RX pushes on each clock edge where rx_valid & rx_ready.
  - Push and pop in the same cycle on one FIFO are both performed; the count is unchanged.
  - Full: push is blocked. Empty: pop is blocked.
  - Pointers wrap modulo 2^DEPTH_LOG2; the count distinguishes full from empty.
- FSM states: IDLE, ACK, RELEASE.
- IDLE:
  - io_read & RX not empty: latch the RX head into the read-data register, pop RX, go to ACK.
  - io_write & TX not full (a same-cycle TX pop counts as freeing a slot): push io_bus into TX, go to ACK.
  - If both io_read and io_write are high, the read has priority; the write is not taken.
  - If the needed FIFO is empty or full, stay in IDLE with no ack; this stalls the core indefinitely.
- ACK:
  - ioack=1 for exactly this cycle.
  - Unconditionally go to RELEASE.
- RELEASE:
  - Wait until io_read=0 and io_write=0, then go to IDLE.
  - This guarantees exactly one transfer per strobe assertion.
- Latency: ioack goes high on the cycle after the edge at which the strobe was sampled with the resource available, giving a minimum 1-cycle stall.
  - Back-to-back transfers need at least 3 cycles each.
- io_bus drive:
  - The read-data register is driven onto io_bus in ACK, and in RELEASE while io_read=1 and the transaction was a read.
  - Otherwise io_bus=Z. The block never drives during writes.
- Strobe dropped before ack: if the FSM is still in IDLE, nothing happens. Once the transfer is taken, it completes even if the strobe drops.
- Reset mid-transaction: the transaction is abandoned, FIFO contents are lost, and no ack is issued.
- ioack, tx_valid, rx_ready and the counts are registered or derived from registered state only. There is no combinational path from io_read/io_write to any output except the io_bus enable.

Decomposition:
- Shared package:
  - FSM state encoding: IO_IDLE=2'd0, IO_ACK=2'd1, IO_RELEASE=2'd2.
  - Default word width constant SEXTIUM_WORD=16.
- Sub-module: sextium_fifo.
  - Parameters: WIDTH, DEPTH_LOG2.
  - Ports: clock, reset, push, pop, din, dout, full, empty, count.
  - First-word-fall-through; instantiated twice (TX and RX).

Test Plan:
- Write: reset, tx_ready=0; io_write=1 with io_bus=16'h1234 → ioack pulses 1 cycle later; tx_count=1; tx_data=16'h1234, tx_valid=1. Drop io_write, then raise tx_ready → tx_valid=0.
- Read: push rx_data=16'hBEEF; assert io_read → ioack next cycle with io_bus=16'hBEEF; rx_count 1→0; io_bus=Z after io_read drops.
- Read stall: io_read with RX empty for 10 cycles → no ack, io_bus=Z. Push 16'h0007 → ack within 2 cycles, data 16'h0007.
- Write stall and pop order: with tx_ready=0, do 4 writes of 1,2,3,4 (ack each) → tx_count=4. A 5th write of 16'h0005 stalls. Pulse tx_ready once → the 5th write is acked; popped order is 1,2,3,4,5.
- Strobe discipline: hold io_write high for 6 cycles → exactly one ack and one push.
- Priority: io_read and io_write high together → only the read is taken.
- Reset mid-transaction: assert reset (0) during ACK → ioack falls immediately, counts read 0, io_bus=Z.

Source files
------------

// File: rtl/sextium_io_port_pkg.sv
// Shared definitions for the Sextium III I/O port: FSM encoding and word width.
package sextium_io_port_pkg;

   localparam int unsigned SEXTIUM_WORD = 16;

   typedef enum logic [1:0] {
      IO_IDLE    = 2'd0,
      IO_ACK     = 2'd1,
      IO_RELEASE = 2'd2
   } io_state_e;

endpackage

// File: rtl/sextium_fifo.sv
// First-word-fall-through FIFO with occupancy count; a pop frees a slot for a same-cycle push.
module sextium_fifo
   import sextium_io_port_pkg::*;
#(
   parameter int unsigned WIDTH      = SEXTIUM_WORD,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  do_push, do_pop;

   // count never exceeds DEPTH, so its MSB alone marks full
   assign full    = count_q[DEPTH_LOG2];
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/sextium_io_port.sv
// Sextium III I/O port: core io_bus/ioack handshake bridged to TX/RX stream FIFOs.
module sextium_io_port
   import sextium_io_port_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 2,
   parameter int unsigned WIDTH      = SEXTIUM_WORD
) (
   input  logic                  clock,
   input  logic                  reset,
   inout  wire logic [WIDTH-1:0] io_bus,
   input  logic                  io_read,
   input  logic                  io_write,
   output logic                  ioack,
   output logic [WIDTH-1:0]      tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [WIDTH-1:0]      rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic [DEPTH_LOG2:0]   rx_count
);

   io_state_e        state_q, state_d;
   logic             rd_q, rd_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic [WIDTH-1:0] rx_head;
   logic             bus_en;

   sextium_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clock (clock),    .reset (reset),
      .push  (tx_push),  .pop   (tx_pop),
      .din   (io_bus),   .dout  (tx_data),
      .full  (tx_full),  .empty (tx_empty),
      .count (tx_count)
   );

   sextium_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clock (clock),    .reset (reset),
      .push  (rx_push),  .pop   (rx_pop),
      .din   (rx_data),  .dout  (rx_head),
      .full  (rx_full),  .empty (rx_empty),
      .count (rx_count)
   );

   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_ready = ~rx_full;
   assign rx_push  = rx_valid & rx_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IO_IDLE;
         rd_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      unique case (state_q)
         IO_IDLE: begin
            // a pending read blocks the write even while RX is empty
            if (io_read) begin
               if (!rx_empty) begin
                  rdata_d = rx_head;
                  rx_pop  = 1'b1;
                  rd_d    = 1'b1;
                  state_d = IO_ACK;
               end
            end else if (io_write && (!tx_full || tx_pop)) begin
               tx_push = 1'b1;
               rd_d    = 1'b0;
               state_d = IO_ACK;
            end
         end
         IO_ACK:     state_d = IO_RELEASE;
         IO_RELEASE: if (!io_read && !io_write) state_d = IO_IDLE;
         default:    state_d = IO_IDLE;
      endcase
   end

   assign ioack  = (state_q == IO_ACK);
   assign bus_en = rd_q && ((state_q == IO_ACK) || (state_q == IO_RELEASE && io_read));
   assign io_bus = bus_en ? rdata_q : 'z;

endmodule

// File: tb/tb_sextium_io_port.sv
// Directed bench for sextium_io_port with TX/RX scoreboards and assertion-based checks.
module tb_sextium_io_port;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        io_read = 1'b0, io_write = 1'b0;
   logic        tx_ready = 1'b0, rx_valid = 1'b0;
   logic        tb_bus_en = 1'b0;
   logic [15:0] tb_bus_val = '0, rx_data = '0;
   wire  [15:0] io_bus;
   logic        ioack, tx_valid, rx_ready;
   logic [15:0] tx_data;
   logic [2:0]  tx_count, rx_count;

   int          total = 0;
   int          bad = 0;
   logic [15:0] tx_exp[$];
   logic [15:0] rx_exp[$];
   logic [15:0] mon_word;

   assign io_bus = tb_bus_en ? tb_bus_val : 'z;

   always #5 clock = ~clock;

   sextium_io_port #(.DEPTH_LOG2(2), .WIDTH(16)) dut (
      .clock    (clock),
      .reset    (reset),
      .io_bus   (io_bus),
      .io_read  (io_read),
      .io_write (io_write),
      .ioack    (ioack),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_count (tx_count),
      .rx_count (rx_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Briefly drive 0 onto the bus; any DUT drive corrupts the value seen.
   task automatic chk_released(input string tag);
      tb_bus_val = '0;
      tb_bus_en  = 1'b1;
      #1;
      check(tag, io_bus, 32'h0);
      tb_bus_en  = 1'b0;
      #1;
   endtask

   task automatic wait_ack(input string tag, input int limit, output int lat);
      lat = 0;
      while (ioack !== 1'b1 && lat < limit) begin
         tick();
         lat++;
      end
      check(tag, ioack, 1);
   endtask

   task automatic push_rx(input logic [15:0] v);
      rx_data  = v;
      rx_valid = 1'b1;
      rx_exp.push_back(v);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] v, input int exp_lat, input string tag);
      int lat;
      tb_bus_val = v;
      tb_bus_en  = 1'b1;
      io_write   = 1'b1;
      tx_exp.push_back(v);
      check({tag, "_pre"}, ioack, 0);
      wait_ack(tag, 8, lat);
      check({tag, "_lat"}, lat, exp_lat);
      io_write  = 1'b0;
      tb_bus_en = 1'b0;
      tick();
      check({tag, "_pulse"}, ioack, 0);
      tick();
   endtask

   task automatic do_read(input string tag, input int limit, input int exp_lat);
      int          lat;
      logic [15:0] e;
      io_read = 1'b1;
      wait_ack(tag, limit, lat);
      if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
      e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 16'hDEAD;
      check({tag, "_data"}, io_bus, e);
      tick();
      check({tag, "_hold"}, io_bus, e);
      io_read = 1'b0;
      chk_released({tag, "_rel"});
      tick();
   endtask

   // Every TX pop is compared against the order in which words were written.
   always @(negedge clock) begin
      if (reset && tx_valid && tx_ready) begin
         check("tx_q_nonempty", tx_exp.size() != 0, 1);
         if (tx_exp.size() != 0) begin
            mon_word = tx_exp.pop_front();
            check("tx_order", tx_data, mon_word);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;

      repeat (3) tick();
      check("rst_ioack", ioack, 0);
      check("rst_tx_count", tx_count, 0);
      check("rst_rx_count", rx_count, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 1);
      chk_released("rst_bus");
      reset = 1'b1;
      tick();

      do_write(16'h1234, 1, "wr1");
      check("wr1_tx_count", tx_count, 1);
      check("wr1_tx_data", tx_data, 16'h1234);
      check("wr1_tx_valid", tx_valid, 1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("wr1_drained_valid", tx_valid, 0);
      check("wr1_drained_count", tx_count, 0);

      push_rx(16'hBEEF);
      check("rd1_rx_count_pre", rx_count, 1);
      do_read("rd1", 8, 1);
      check("rd1_rx_count_post", rx_count, 0);

      io_read = 1'b1;
      acks = 0;
      repeat (10) begin
         tick();
         if (ioack) acks++;
      end
      check("rd_stall_acks", acks, 0);
      chk_released("rd_stall_bus");
      push_rx(16'h0007);
      do_read("rd_stall", 2, -1);

      for (int i = 1; i <= 4; i++) do_write(16'(i), 1, "wr_fill");
      check("fill_tx_count", tx_count, 4);
      tb_bus_val = 16'h0005;
      tb_bus_en  = 1'b1;
      io_write   = 1'b1;
      tx_exp.push_back(16'h0005);
      acks = 0;
      repeat (3) begin
         tick();
         if (ioack) acks++;
      end
      check("wr5_stall_acks", acks, 0);
      check("wr5_stall_count", tx_count, 4);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("wr5_ack", ioack, 1);
      check("wr5_count", tx_count, 4);
      io_write  = 1'b0;
      tb_bus_en = 1'b0;
      tick();
      tick();
      tx_ready = 1'b1;
      repeat (4) tick();
      tx_ready = 1'b0;
      check("drain_count", tx_count, 0);
      check("drain_scoreboard", tx_exp.size(), 0);

      tb_bus_val = 16'h0066;
      tb_bus_en  = 1'b1;
      io_write   = 1'b1;
      tx_exp.push_back(16'h0066);
      acks = 0;
      repeat (6) begin
         tick();
         if (ioack) acks++;
      end
      io_write  = 1'b0;
      tb_bus_en = 1'b0;
      tick();
      tick();
      check("strobe_acks", acks, 1);
      check("strobe_tx_count", tx_count, 1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("strobe_drained", tx_count, 0);

      push_rx(16'h00AA);
      tb_bus_val = 16'h0BAD;
      tb_bus_en  = 1'b1;
      io_read    = 1'b1;
      io_write   = 1'b1;
      tick();
      check("prio_ack", ioack, 1);
      io_write  = 1'b0;
      tb_bus_en = 1'b0;
      #1;
      check("prio_data", io_bus, (rx_exp.size() != 0) ? rx_exp.pop_front() : 16'hDEAD);
      io_read = 1'b0;
      tick();
      tick();
      check("prio_tx_count", tx_count, 0);
      check("prio_rx_count", rx_count, 0);
      check("prio_tx_valid", tx_valid, 0);

      do_write(16'h0077, 1, "wr_rst");
      push_rx(16'h0055);
      io_read = 1'b1;
      tick();
      check("rst_mid_ack", ioack, 1);
      #1;
      reset = 1'b0;
      #1;
      check("rst_mid_ioack", ioack, 0);
      check("rst_mid_tx_count", tx_count, 0);
      check("rst_mid_rx_count", rx_count, 0);
      chk_released("rst_mid_bus");
      tx_exp.delete();
      rx_exp.delete();
      io_read = 1'b0;
      tick();
      reset = 1'b1;
      acks = 0;
      repeat (3) begin
         tick();
         if (ioack) acks++;
      end
      check("rst_mid_no_ack", acks, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
